ex_stage_unit: RTL and testbench
================================

Name: ex_stage_unit

Overview:
Execute stage sitting on the read side of the ID/EX pipeline register. It consumes the latched pc, rd1, rd2, instruction word and immediate, and produces a registered EX/MEM-bound result. Single-cycle ALU, address and branch ops complete in one cycle. MUL runs on an iterative shift-add unit and back-pressures decode through stall_o.

Parameters:
XLEN, 64, datapath width for operands, results and pc
MUL_CNT_W, 6, iteration counter width; log2(XLEN)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  ID/EX slot holds a real instruction
pc_reg  input  XLEN  pc of the instruction in ID/EX
rd1_reg  input  XLEN  rs1 value
rd2_reg  input  XLEN  rs2 value
wr_reg  input  32  instruction word; opcode [6:0], rd [11:7], funct3 [14:12], funct7 [31:25]
imm_gen_reg  input  XLEN  sign-extended immediate
stall_o  output  1  upstream must hold ID/EX contents this cycle
out_valid  output  1  result registers hold a completed instruction
alu_result  output  XLEN  ALU/MUL result or memory address
store_data  output  XLEN  rd2 passthrough for stores
rd_addr  output  5  destination register
reg_write  output  1  result is written back
mem_read  output  1  load
mem_write  output  1  store
branch_taken  output  1  conditional branch resolved taken
branch_target  output  XLEN  pc_reg + imm_gen_reg

Behaviour:
- Reset (rst_n=0 at an edge) clears every output register to 0 and sets the FSM to IDLE. A multiply in flight is discarded; no out_valid is ever produced for it.
- Supported ops:
  - 0110011: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU; MUL when funct7=0000001 and funct3=000.
  - 0010011: I-type equivalents using imm_gen_reg.
  - 0000011 load and 0100011 store: alu_result = rd1 + imm.
  - 1100011: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- Unsupported opcodes give no output (out_valid=0 next cycle) and no stall.
- Arithmetic is modulo 2^XLEN. Shift amount is operand[5:0]. SLT is signed; SLTU is unsigned. MUL returns the low XLEN bits of the product.
- FSM states: IDLE, MUL_BUSY.
- IDLE with in_valid and a non-MUL op: outputs are registered at that edge, so out_valid=1 in the next cycle (latency 1). stall_o=0.
- IDLE with in_valid and MUL (accept cycle T):
  - stall_o=1 combinationally.
  - Latch multiplicand=rd1 and multiplier=rd2, clear the accumulator, set count=0, and go to MUL_BUSY.
  - out_valid=0 next cycle (bubble).
- MUL_BUSY, each cycle:
  - If multiplier[0] is set, accumulator += multiplicand.
  - Shift multiplicand left by 1 and multiplier right by 1; count++.
  - The last busy cycle is count==63.
  - stall_o=1 in every busy cycle except the last. In the last cycle stall_o=0, so ID/EX advances at that edge.
  - At that same edge: result registered, out_valid=1, rd_addr/reg_write from the latched instruction, state returns to IDLE.
- Default MUL timing: stall_o high for cycles T..T+63, out_valid high in T+65.
- ID/EX inputs are ignored while in MUL_BUSY. The next instruction is sampled in the first IDLE cycle after completion.
- reg_write=1 for ALU, MUL and load ops; 0 for store and branch.
- branch_taken=0 for all non-branch ops. branch_target is always pc+imm.
- out_valid=0 when in_valid=0. Data outputs then hold their last value.

Optional Feature:
MUL_EARLY_EXIT_EN:
- When defined, a MUL_BUSY cycle is also the last cycle if the multiplier after this cycle's shift is zero. stall_o and completion follow the same last-cycle rules. A zero multiplier therefore completes after 1 busy cycle.
- When undefined, MUL always takes exactly 64 busy cycles.

Test Plan:
- Reset mid-MUL: accept MUL 7*9, pull rst_n low at T+10 -> at the next edge all outputs are 0 and the FSM is IDLE; out_valid stays 0 through T+80.
- ADD, one cycle: rd1=5, rd2=0xFFFFFFFFFFFFFFFD, rd=x3 -> next cycle out_valid=1, alu_result=2, rd_addr=3, reg_write=1, stall_o=0 throughout.
- BLT signed vs BLTU: rd1=-1, rd2=1, pc=0x100, imm=0x20 -> BLT gives branch_taken=1 with branch_target=0x120; BLTU gives branch_taken=0.
- MUL default timing: rd1=3, rd2=5 accepted at T -> stall_o=1 for T..T+63 and 0 at T+64; out_valid=1 only at T+65 with alu_result=15.
- MUL_EARLY_EXIT_EN defined, rd1=3, rd2=5 -> last busy cycle T+3 with stall_o=0; out_valid at T+4 with alu_result=15. With rd2=0 -> out_valid at T+2, result 0.
- Store then unsupported opcode: SD with rd1=0x1000, imm=8, rd2=0xAB -> alu_result=0x1008, store_data=0xAB, mem_write=1, reg_write=0. Opcode 1111111 next -> out_valid=0, stall_o=0.

Source files
------------

// File: rtl/ex_stage_unit.sv
// ex_stage_unit: EX stage with 1-cycle ALU/address/branch ops and a 64-step shift-add MUL; define MUL_EARLY_EXIT_EN to finish MUL once the multiplier is exhausted
module ex_stage_unit #(
  parameter int XLEN      = 64,
  parameter int MUL_CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] pc_reg,
  input  logic [XLEN-1:0] rd1_reg,
  input  logic [XLEN-1:0] rd2_reg,
  input  logic [31:0]     wr_reg,
  input  logic [XLEN-1:0] imm_gen_reg,
  output logic            stall_o,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd_addr,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  logic [0:0]           r_state;
  logic [XLEN-1:0]      r_mcand;
  logic [XLEN-1:0]      r_mplier;
  logic [XLEN-1:0]      r_acc;
  logic [XLEN-1:0]      r_tgt;
  logic [MUL_CNT_W-1:0] r_cnt;
  logic [4:0]           r_rd;
  logic [6:0]           w_op;
  logic [6:0]           w_f7;
  logic [2:0]           w_f3;
  logic                 w_is_r;
  logic                 w_is_i;
  logic                 w_is_ld;
  logic                 w_is_st;
  logic                 w_is_br;
  logic                 w_is_mul;
  logic                 w_supp;
  logic                 w_eq;
  logic                 w_lt;
  logic                 w_ltu;
  logic                 w_taken;
  logic                 w_last;
  logic                 w_unused;
  logic [5:0]           w_sh;
  logic [XLEN-1:0]      w_b;
  logic [XLEN-1:0]      w_sra;
  logic [XLEN-1:0]      w_alu;
  logic [XLEN-1:0]      w_res;
  logic [XLEN-1:0]      w_acc_nxt;

  assign w_op     = wr_reg[6:0];
  assign w_f3     = wr_reg[14:12];
  assign w_f7     = wr_reg[31:25];
  assign w_unused = ^wr_reg[24:15];
  assign w_is_r   = w_op == 7'b0110011;
  assign w_is_i   = w_op == 7'b0010011;
  assign w_is_ld  = w_op == 7'b0000011;
  assign w_is_st  = w_op == 7'b0100011;
  assign w_is_br  = w_op == 7'b1100011;
  assign w_is_mul = w_is_r && w_f7 == 7'b0000001 && w_f3 == 3'b000;
  assign w_supp   = w_is_r || w_is_i || w_is_ld || w_is_st || w_is_br;
  assign w_b      = (w_is_r || w_is_br) ? rd2_reg : imm_gen_reg;
  assign w_sh     = w_b[5:0];
  assign w_sra    = $signed(rd1_reg) >>> w_sh;
  assign w_eq     = rd1_reg == rd2_reg;
  assign w_lt     = $signed(rd1_reg) < $signed(rd2_reg);
  assign w_ltu    = rd1_reg < rd2_reg;
  assign w_taken  = w_is_br && (w_f3 == 3'b000 ? w_eq :
                                w_f3 == 3'b001 ? !w_eq :
                                w_f3 == 3'b100 ? w_lt :
                                w_f3 == 3'b101 ? !w_lt :
                                w_f3 == 3'b110 ? w_ltu :
                                w_f3 == 3'b111 ? !w_ltu : 1'b0);
  assign w_res     = (w_is_ld || w_is_st) ? rd1_reg + imm_gen_reg : w_alu;
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
`ifdef MUL_EARLY_EXIT_EN
  assign w_last = (r_cnt == '1) || (r_mplier[XLEN-1:1] == '0);
`else
  assign w_last = r_cnt == '1;
`endif
  assign stall_o = (r_state == S_BUSY) ? !w_last : (in_valid && w_is_mul);

  // Register/immediate ALU selected by funct3; funct7[5] picks SUB (R only) and SRA
  always_comb begin
    w_alu = rd1_reg + w_b;
    case (w_f3)
      3'b000:  w_alu = (w_is_r && w_f7[5]) ? rd1_reg - w_b : rd1_reg + w_b;
      3'b001:  w_alu = rd1_reg << w_sh;
      3'b010:  w_alu = {{(XLEN-1){1'b0}}, $signed(rd1_reg) < $signed(w_b)};
      3'b011:  w_alu = {{(XLEN-1){1'b0}}, rd1_reg < w_b};
      3'b100:  w_alu = rd1_reg ^ w_b;
      3'b101:  w_alu = w_f7[5] ? w_sra : rd1_reg >> w_sh;
      3'b110:  w_alu = rd1_reg | w_b;
      default: w_alu = rd1_reg & w_b;
    endcase
  end

  // FSM, shift-add multiplier and EX/MEM result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_acc         <= '0;
      r_tgt         <= '0;
      r_cnt         <= '0;
      r_rd          <= '0;
      out_valid     <= 1'b0;
      alu_result    <= '0;
      store_data    <= '0;
      rd_addr       <= '0;
      reg_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else if (r_state == S_BUSY) begin
      r_acc     <= w_acc_nxt;
      r_mcand   <= r_mcand << 1;
      r_mplier  <= r_mplier >> 1;
      r_cnt     <= r_cnt + 1'b1;
      out_valid <= w_last;
      if (w_last) begin
        r_state       <= S_IDLE;
        alu_result    <= w_acc_nxt;
        rd_addr       <= r_rd;
        reg_write     <= 1'b1;
        mem_read      <= 1'b0;
        mem_write     <= 1'b0;
        branch_taken  <= 1'b0;
        branch_target <= r_tgt;
      end
    end else if (in_valid && w_is_mul) begin
      r_state   <= S_BUSY;
      r_mcand   <= rd1_reg;
      r_mplier  <= rd2_reg;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_rd      <= wr_reg[11:7];
      r_tgt     <= pc_reg + imm_gen_reg;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid && w_supp;
      if (in_valid && w_supp) begin
        alu_result    <= w_res;
        store_data    <= rd2_reg;
        rd_addr       <= wr_reg[11:7];
        reg_write     <= w_is_r || w_is_i || w_is_ld;
        mem_read      <= w_is_ld;
        mem_write     <= w_is_st;
        branch_taken  <= w_taken;
        branch_target <= pc_reg + imm_gen_reg;
      end
    end
  end
endmodule

// File: tb/tb_ex_stage_unit.sv
// tb_ex_stage_unit: directed and randomized checks of ex_stage_unit against a behavioural model
module tb_ex_stage_unit;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_NO = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] pc_reg = '0;
  logic [63:0] rd1_reg = '0;
  logic [63:0] rd2_reg = '0;
  logic [31:0] wr_reg = '0;
  logic [63:0] imm_gen_reg = '0;
  logic        stall_o;
  logic        out_valid;
  logic [63:0] alu_result;
  logic [63:0] store_data;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch_taken;
  logic [63:0] branch_target;
  int          checks = 0;
  int          errors = 0;

  ex_stage_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pc_reg(pc_reg),
    .rd1_reg(rd1_reg), .rd2_reg(rd2_reg), .wr_reg(wr_reg), .imm_gen_reg(imm_gen_reg),
    .stall_o(stall_o), .out_valid(out_valid), .alu_result(alu_result),
    .store_data(store_data), .rd_addr(rd_addr), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch_taken(branch_taken),
    .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] imm, input logic [63:0] pc);
    wr_reg      = {f7, 10'd0, f3, rd, op};
    rd1_reg     = a;
    rd2_reg     = b;
    imm_gen_reg = imm;
    pc_reg      = pc;
    in_valid    = 1'b1;
  endtask

  // What the instruction means architecturally, independent of any pipeline timing
  function automatic void model(input logic [31:0] w, input logic [63:0] a, input logic [63:0] rb,
                                input logic [63:0] imm, output logic v, output logic [63:0] res,
                                output logic rw, output logic mr, output logic mw, output logic bt);
    logic [6:0]         op;
    logic [2:0]         f3;
    logic [63:0]        b;
    int                 sh;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    op = w[6:0];
    f3 = w[14:12];
    b  = (op == OP_R) ? rb : imm;
    sh = int'(b[5:0]);
    sa = a;
    sb = b;
    v  = 1'b1;
    res = '0;
    rw = 1'b0;
    mr = 1'b0;
    mw = 1'b0;
    bt = 1'b0;
    if (op == OP_R && w[31:25] == 7'b0000001) begin
      res = a * rb;
      rw  = 1'b1;
    end else if (op == OP_R || op == OP_I) begin
      rw = 1'b1;
      case (f3)
        3'd0: res = (op == OP_R && w[30]) ? a - b : a + b;
        3'd1: res = a << sh;
        3'd2: res = (sa < sb) ? 64'd1 : 64'd0;
        3'd3: res = (a < b) ? 64'd1 : 64'd0;
        3'd4: res = a ^ b;
        3'd5: begin
          sa  = sa >>> sh;
          res = w[30] ? sa : a >> sh;
        end
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end else if (op == OP_LD || op == OP_ST) begin
      res = a + imm;
      rw  = op == OP_LD;
      mr  = op == OP_LD;
      mw  = op == OP_ST;
    end else if (op == OP_BR) begin
      sb = rb;
      sa = a;
      case (f3)
        3'd0: bt = a == rb;
        3'd1: bt = a != rb;
        3'd4: bt = sa < sb;
        3'd5: bt = sa >= sb;
        3'd6: bt = a < rb;
        3'd7: bt = a >= rb;
        default: bt = 1'b0;
      endcase
    end else begin
      v = 1'b0;
    end
  endfunction

  task automatic run_one(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] imm, input logic [63:0] pc);
    logic        v, rw, mr, mw, bt;
    logic [63:0] res;
    drive(op, f3, f7, rd, a, b, imm, pc);
    model(wr_reg, a, b, imm, v, res, rw, mr, mw, bt);
    #1;
    chk1({tag, "_stall"}, stall_o, 1'b0);
    tick();
    chk1({tag, "_valid"}, out_valid, v);
    if (v) begin
      if (op != OP_BR) chk({tag, "_res"}, alu_result, res);
      chk1({tag, "_rw"}, reg_write, rw);
      chk1({tag, "_mr"}, mem_read, mr);
      chk1({tag, "_mw"}, mem_write, mw);
      chk1({tag, "_bt"}, branch_taken, bt);
      chk({tag, "_tgt"}, branch_target, pc + imm);
      if (rw) chk({tag, "_rd"}, 64'(rd_addr), 64'(rd));
      if (mw) chk({tag, "_sd"}, store_data, b);
    end
  endtask

  task automatic run_mul(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd);
    int n;
    int cyc;
    int ov;
`ifdef MUL_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < 64; i++) if (b[i]) n = i + 1;
`else
    n = 64;
`endif
    drive(OP_R, 3'd0, 7'b0000001, rd, a, b, 64'h40, 64'h2000);
    #1;
    chk1({tag, "_stall_accept"}, stall_o, 1'b1);
    tick();
    cyc = 1;
    ov  = 0;
    while (stall_o && cyc < 200) begin
      if (out_valid) ov++;
      tick();
      cyc++;
    end
    chk({tag, "_last_cycle"}, 64'(cyc), 64'(n));
    chk({tag, "_early_valid"}, 64'(ov), 64'd0);
    chk1({tag, "_valid_last"}, out_valid, 1'b0);
    in_valid = 1'b0;
    tick();
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_res"}, alu_result, a * b);
    chk({tag, "_rd"}, 64'(rd_addr), 64'(rd));
    chk1({tag, "_rw"}, reg_write, 1'b1);
    chk1({tag, "_mw"}, mem_write, 1'b0);
    chk1({tag, "_bt"}, branch_taken, 1'b0);
    chk({tag, "_tgt"}, branch_target, 64'h2040);
    tick();
    chk1({tag, "_valid_after"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [2:0]  br_f3 [6];
    logic [63:0] a, b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          ov;
    br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    tick();
    tick();
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_stall", stall_o, 1'b0);
    chk("rst_res", alu_result, 64'd0);
    chk("rst_tgt", branch_target, 64'd0);
    chk1("rst_rw", reg_write, 1'b0);
    rst_n = 1'b1;
    run_one("add", OP_R, 3'd0, 7'd0, 5'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 64'd0);
    chk("add_const", alu_result, 64'd2);
    in_valid = 1'b0;
    tick();
    chk1("idle_valid", out_valid, 1'b0);
    chk("idle_hold", alu_result, 64'd2);
    run_one("blt", OP_BR, 3'd4, 7'd0, 5'd0, '1, 64'd1, 64'h20, 64'h100);
    chk1("blt_const", branch_taken, 1'b1);
    chk("blt_tgt_const", branch_target, 64'h120);
    run_one("bltu", OP_BR, 3'd6, 7'd0, 5'd0, '1, 64'd1, 64'h20, 64'h100);
    chk1("bltu_const", branch_taken, 1'b0);
    run_one("sd", OP_ST, 3'd3, 7'd0, 5'd0, 64'h1000, 64'hAB, 64'd8, 64'd0);
    chk("sd_addr_const", alu_result, 64'h1008);
    chk("sd_data_const", store_data, 64'hAB);
    run_one("unsup", OP_NO, 3'd0, 7'd0, 5'd4, 64'd1, 64'd2, 64'd3, 64'd0);
    run_mul("mul_3x5", 64'd3, 64'd5, 5'd7);
    run_mul("mul_by0", 64'd9, 64'd0, 5'd8);
    drive(OP_R, 3'd0, 7'b0000001, 5'd9, 64'd7, 64'd9, 64'd0, 64'd0);
    #1;
    chk1("rmul_stall", stall_o, 1'b1);
    repeat (10) tick();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk1("rmul_valid", out_valid, 1'b0);
    chk1("rmul_stall_rst", stall_o, 1'b0);
    chk("rmul_res", alu_result, 64'd0);
    chk("rmul_rd", 64'(rd_addr), 64'd0);
    chk1("rmul_rw", reg_write, 1'b0);
    chk("rmul_tgt", branch_target, 64'd0);
    rst_n = 1'b1;
    ov = 0;
    repeat (70) begin
      tick();
      if (out_valid) ov++;
    end
    chk("rmul_no_valid", 64'(ov), 64'd0);
    run_one("post_rst_add", OP_R, 3'd0, 7'd0, 5'd1, 64'd10, 64'd20, 64'd0, 64'd0);
    for (int k = 0; k < 40; k++) begin
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      f3 = 3'($urandom_range(0, 7));
      case (k % 10)
        0, 1, 2: begin
          f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
          run_one("rnd_r", OP_R, f3, f7, 5'($urandom), a, b, {$urandom, $urandom}, {$urandom, $urandom});
        end
        3, 4: run_one("rnd_i", OP_I, f3, {1'b0, 1'($urandom), 5'd0}, 5'($urandom), a, b,
                      {$urandom, $urandom}, {$urandom, $urandom});
        5: run_one("rnd_ld", OP_LD, f3, 7'd0, 5'($urandom), a, b, {$urandom, $urandom}, 64'd0);
        6: run_one("rnd_st", OP_ST, f3, 7'd0, 5'($urandom), a, b, {$urandom, $urandom}, 64'd0);
        7, 8: run_one("rnd_br", OP_BR, br_f3[$urandom_range(0, 5)], 7'd0, 5'd0, a, b,
                      {$urandom, $urandom}, {$urandom, $urandom});
        default: if (k % 20 == 9) run_mul("rnd_mul", a, {32'd0, 32'($urandom_range(0, 1000))}, 5'($urandom));
                 else run_mul("rnd_mul_w", a, b, 5'($urandom));
      endcase
    end
    in_valid = 1'b0;
    tick();
    chk1("end_idle", out_valid, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
